// File: rtl/mult_div_pkg.sv
// Shared types and constants for the mult/div sequencer.
package mult_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  // Two's-complement negate when neg is set; also serves as |x| with neg = x[31].
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Handshake/result bundle between the main control FSM and the mult/div sequencer.
interface mult_div_ctrl_if;

  logic        MultStart;
  logic        DivStart;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        HiCtrl;
  logic        LoCtrl;
  logic        MultCtrl;

  modport master (
    output MultStart, DivStart, SrcA, SrcB,
    input  Busy, Done, DivZero, HiOut, LoOut, HiCtrl, LoCtrl, MultCtrl
  );

  modport slave (
    input  MultStart, DivStart, SrcA, SrcB,
    output Busy, Done, DivZero, HiOut, LoOut, HiCtrl, LoCtrl, MultCtrl
  );

endinterface

// File: rtl/div_restore_step.sv
// One unsigned restoring-division iteration: shift {rem, quot} left, trial-subtract the divisor.
module div_restore_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quot_o
);

  logic [32:0] shifted_s;

  // The partial remainder stays below the divisor, so a successful subtract fits in 32 bits.
  always_comb begin
    shifted_s = {rem_i, quot_i[31]};
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o  = shifted_s[31:0] - divisor_i;
      quot_o = {quot_i[30:0], 1'b1};
    end else begin
      rem_o  = shifted_s[31:0];
      quot_o = {quot_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle sequencer for MIPS mult/div: radix-2 Booth multiply and restoring divide,
// with registered HI/LO results and write-enable pulses.
module mult_div_ctrl
  import mult_div_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mult_div_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        qr_q, qr_d;
  logic               q1_q, q1_d;
  logic [31:0]        m_q, m_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               hictrl_q, hictrl_d;
  logic               loctrl_q, loctrl_d;
  logic               multctrl_q, multctrl_d;

  logic [32:0]        booth_sum_s;
  logic [31:0]        div_rem_s;
  logic [31:0]        div_quot_s;

  // A is widened by one bit so that subtracting M = -2^31 cannot overflow before the shift.
  always_comb begin
    case ({qr_q[0], q1_q})
      2'b10:   booth_sum_s = {acc_q[31], acc_q} - {m_q[31], m_q};
      2'b01:   booth_sum_s = {acc_q[31], acc_q} + {m_q[31], m_q};
      default: booth_sum_s = {acc_q[31], acc_q};
    endcase
  end

  div_restore_step u_div_step (
    .rem_i     (acc_q),
    .quot_i    (qr_q),
    .divisor_i (m_q),
    .rem_o     (div_rem_s),
    .quot_o    (div_quot_s)
  );

  // Next-state and datapath update; pulse outputs default low every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    qr_d       = qr_q;
    q1_d       = q1_q;
    m_d        = m_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    divzero_d  = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    hictrl_d   = 1'b0;
    loctrl_d   = 1'b0;
    multctrl_d = multctrl_q;

    case (state_q)
      S_IDLE: begin
        if (bus.MultStart) begin
          state_d    = S_MULT;
          busy_d     = 1'b1;
          multctrl_d = SEL_MULT;
          cnt_d      = '0;
          acc_d      = 32'd0;
          qr_d       = bus.SrcB;
          q1_d       = 1'b0;
          m_d        = bus.SrcA;
        end else if (bus.DivStart) begin
          busy_d     = 1'b1;
          multctrl_d = SEL_DIV;
          sa_d       = bus.SrcA[31];
          sb_d       = bus.SrcB[31];
          if (bus.SrcB != 32'd0) begin
            state_d = S_DIV;
            cnt_d   = '0;
            acc_d   = 32'd0;
            qr_d    = neg_if(bus.SrcA[31], bus.SrcA);
            m_d     = neg_if(bus.SrcB[31], bus.SrcB);
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            divzero_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MULT: begin
        acc_d = booth_sum_s[32:1];
        qr_d  = {booth_sum_s[0], qr_q[31:1]};
        q1_d  = qr_q[0];
        if (cnt_q == LAST_ITER) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          done_d   = 1'b1;
          hictrl_d = 1'b1;
          loctrl_d = 1'b1;
          hi_d     = booth_sum_s[32:1];
          lo_d     = {booth_sum_s[0], qr_q[31:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DIV: begin
        acc_d = div_rem_s;
        qr_d  = div_quot_s;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Sign fix-up; 0x80000000 / -1 wraps naturally to quotient 0x80000000.
      S_FIX: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        hictrl_d = 1'b1;
        loctrl_d = 1'b1;
        hi_d     = neg_if(sa_q, acc_q);
        lo_d     = neg_if(sa_q ^ sb_q, qr_q);
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= 32'd0;
      qr_q       <= 32'd0;
      q1_q       <= 1'b0;
      m_q        <= 32'd0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      divzero_q  <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      hictrl_q   <= 1'b0;
      loctrl_q   <= 1'b0;
      multctrl_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      qr_q       <= qr_d;
      q1_q       <= q1_d;
      m_q        <= m_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      divzero_q  <= divzero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      hictrl_q   <= hictrl_d;
      loctrl_q   <= loctrl_d;
      multctrl_q <= multctrl_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.DivZero  = divzero_q;
  assign bus.HiOut    = hi_q;
  assign bus.LoOut    = lo_q;
  assign bus.HiCtrl   = hictrl_q;
  assign bus.LoCtrl   = loctrl_q;
  assign bus.MultCtrl = multctrl_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl against a plain-arithmetic reference model.
module tb_mult_div_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mult_div_ctrl_if bus_if ();

  mult_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Launch one operation and follow it to completion; poke injects a DivStart while busy.
  task automatic run_op(input bit ms, input bit ds, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    bit          is_mult;
    bit          dz;
    longint      la, lb, eq, er, prod;
    logic [31:0] eh, el;
    int          lat, got_lat, cyc, ndone, tail;
    bit          seen;

    is_mult = ms;
    dz      = !ms && (b == 32'd0);
    la      = longint'($signed(a));
    lb      = longint'($signed(b));
    if (is_mult) begin
      prod = la * lb;
      eh   = prod[63:32];
      el   = prod[31:0];
      lat  = 32;
    end else if (!dz) begin
      eq  = la / lb;
      er  = la % lb;
      eh  = er[31:0];
      el  = eq[31:0];
      lat = 33;
    end else begin
      eh  = model_hi;
      el  = model_lo;
      lat = 0;
    end

    @(negedge clk);
    bus_if.MultStart = ms;
    bus_if.DivStart  = ds;
    bus_if.SrcA      = a;
    bus_if.SrcB      = b;
    @(posedge clk);

    cyc     = 0;
    ndone   = 0;
    seen    = 1'b0;
    got_lat = -1;
    tail    = poke ? 40 : 1;
    while (cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus_if.MultStart = 1'b0;
        bus_if.DivStart  = 1'b0;
        bus_if.SrcA      = 32'($urandom);
        bus_if.SrcB      = 32'($urandom);
        check_val("busy_rise", 64'(bus_if.Busy), 64'd1);
      end
      if (poke && cyc == 5) bus_if.DivStart = 1'b1;
      if (poke && cyc == 6) bus_if.DivStart = 1'b0;
      if (bus_if.Done) begin
        ndone++;
        if (!seen) begin
          seen    = 1'b1;
          got_lat = cyc;
          check_val("hi", 64'(bus_if.HiOut), 64'(eh));
          check_val("lo", 64'(bus_if.LoOut), 64'(el));
          check_val("hictrl", 64'(bus_if.HiCtrl), 64'(!dz));
          check_val("loctrl", 64'(bus_if.LoCtrl), 64'(!dz));
          check_val("divzero", 64'(bus_if.DivZero), 64'(dz));
          check_val("multctrl", 64'(bus_if.MultCtrl), 64'(!is_mult));
        end
      end
      if (seen && cyc == got_lat + 1) begin
        check_val("busy_fall", 64'(bus_if.Busy), 64'd0);
      end
      cyc++;
      if (seen && cyc > got_lat + tail) break;
    end
    check_val("latency", 64'(got_lat), 64'(lat));
    check_val("done_count", 64'(ndone), 64'd1);
    if (!dz) begin
      model_hi = eh;
      model_lo = el;
    end
  endtask

  task automatic reset_mid_divide();
    int ndone;
    @(negedge clk);
    bus_if.DivStart = 1'b1;
    bus_if.SrcA     = 32'd1000;
    bus_if.SrcB     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus_if.DivStart = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_busy", 64'(bus_if.Busy), 64'd0);
    check_val("rst_hi", 64'(bus_if.HiOut), 64'd0);
    check_val("rst_lo", 64'(bus_if.LoOut), 64'd0);
    check_val("rst_multctrl", 64'(bus_if.MultCtrl), 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.Done) ndone++;
    end
    check_val("rst_no_done", 64'(ndone), 64'd0);
  endtask

  initial begin
    int kind;
    total    = 0;
    bad      = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset    = 1'b1;
    bus_if.MultStart = 1'b0;
    bus_if.DivStart  = 1'b0;
    bus_if.SrcA      = 32'd0;
    bus_if.SrcB      = 32'd0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", 64'(bus_if.Busy), 64'd0);
    check_val("reset_done", 64'(bus_if.Done), 64'd0);
    check_val("reset_hi", 64'(bus_if.HiOut), 64'd0);
    check_val("reset_lo", 64'(bus_if.LoOut), 64'd0);
    check_val("reset_ctrl", 64'({bus_if.HiCtrl, bus_if.LoCtrl, bus_if.MultCtrl, bus_if.DivZero}), 64'd0);
    reset = 1'b0;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 1'b1);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      run_op(kind != 1, kind != 0, pick_operand(), pick_operand(), 1'b0);
    end

    reset_mid_divide();
    run_op(1'b1, 1'b0, 32'd2, 32'd5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
